// File: rtl/clk_run_ctrl.sv
// rtl/clk_run_ctrl.sv - clock-enable pacer for the single-cycle CPU core
//
// Produces a one-sys_clk-wide cpu_en pulse in one of four modes (halt,
// divided run, debounced single-step, full speed) and latches a sticky
// STOPPED state when the core raises halt_req.

module clk_run_ctrl #(
  parameter int CNT_W  = 26,
  parameter int DB_CNT = 1000000,
  parameter int DB_W   = 20
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] div_val,
  input  logic             step_btn,
  input  logic             halt_req,
  output logic             cpu_en,
  output logic [31:0]      tick_cnt,
  output logic [1:0]       state,
  output logic             stopped
);

  // FSM state encoding (also the value seen on the state port)
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_RUN     = 2'b01;
  localparam logic [1:0] ST_STEP    = 2'b10;
  localparam logic [1:0] ST_STOPPED = 2'b11;

  // mode input encoding
  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_DIV  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;
  localparam logic [1:0] MODE_FULL = 2'b11;

  // last value of the debounce counter before the new level is accepted
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CNT - 1);

  logic [1:0]       state_next;
  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] div_lat;
  logic             div_active;
  logic             div_hit;
  logic             en_next;
  logic             btn_meta;
  logic             btn_sync;
  logic             db_level;
  logic [DB_W-1:0]  db_cnt;
  logic             step_pulse;

  // Next-state decode; halt_req outranks mode in RUN/STEP, STOPPED waits for mode 00
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (mode == MODE_DIV || mode == MODE_FULL) begin
          state_next = ST_RUN;
        end else if (mode == MODE_STEP) begin
          state_next = ST_STEP;
        end
      end
      ST_RUN: begin
        if (halt_req) begin
          state_next = ST_STOPPED;
        end else if (mode == MODE_HALT) begin
          state_next = ST_IDLE;
        end else if (mode == MODE_STEP) begin
          state_next = ST_STEP;
        end
      end
      ST_STEP: begin
        if (halt_req) begin
          state_next = ST_STOPPED;
        end else if (mode == MODE_HALT) begin
          state_next = ST_IDLE;
        end else if (mode == MODE_DIV || mode == MODE_FULL) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        if (mode == MODE_HALT) begin
          state_next = ST_IDLE;
        end
      end
    endcase
  end

  // Enable decision for the next cycle; halt_req suppresses every source
  always_comb begin
    div_active = (state == ST_RUN) && (mode == MODE_DIV);
    div_hit    = div_active && (div_cnt == div_lat);
    en_next    = 1'b0;
    if (!halt_req) begin
      if (state == ST_RUN && mode == MODE_FULL) begin
        en_next = 1'b1;
      end else if (div_hit) begin
        en_next = 1'b1;
      end else if (state == ST_STEP && step_pulse) begin
        en_next = 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Divider: held at zero (tracking div_val) outside divided run, so entry and
  // a 11->01 switch both start a fresh period; div_val is sampled only at wrap
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      div_lat <= '0;
    end else if (!div_active || div_hit) begin
      div_cnt <= '0;
      div_lat <= div_val;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Two-flop synchronizer for the raw push-button
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= step_btn;
      btn_sync <= btn_meta;
    end
  end

  // Debounce: accept a new level after DB_CNT consecutive differing cycles;
  // only a rising acceptance produces step_pulse, so release bounce is silent
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      db_level   <= 1'b0;
      db_cnt     <= '0;
      step_pulse <= 1'b0;
    end else if (btn_sync == db_level) begin
      db_cnt     <= '0;
      step_pulse <= 1'b0;
    end else if (db_cnt == DB_LAST) begin
      db_level   <= btn_sync;
      db_cnt     <= '0;
      step_pulse <= btn_sync;
    end else begin
      db_cnt     <= db_cnt + 1'b1;
      step_pulse <= 1'b0;
    end
  end

  // Registered enable and free-running (wrapping) pulse counter
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      cpu_en   <= 1'b0;
      tick_cnt <= '0;
    end else begin
      cpu_en   <= en_next;
      tick_cnt <= tick_cnt + {31'b0, cpu_en};
    end
  end

  assign stopped = (state == ST_STOPPED);

endmodule

// File: tb/tb_clk_run_ctrl.sv
// tb/tb_clk_run_ctrl.sv - self-checking bench for clk_run_ctrl

module tb_clk_run_ctrl;

  localparam int CNT_W = 26;
  localparam int DB    = 8;
  localparam int DB_W  = 4;

  logic             sys_clk = 1'b0;
  logic             reset = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [CNT_W-1:0] div_val = '0;
  logic             step_btn = 1'b0;
  logic             halt_req = 1'b0;
  logic             cpu_en;
  logic [31:0]      tick_cnt;
  logic [1:0]       state;
  logic             stopped;

  clk_run_ctrl #(.CNT_W(CNT_W), .DB_CNT(DB), .DB_W(DB_W)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .mode    (mode),
    .div_val (div_val),
    .step_btn(step_btn),
    .halt_req(halt_req),
    .cpu_en  (cpu_en),
    .tick_cnt(tick_cnt),
    .state   (state),
    .stopped (stopped)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: cycles left until the next divided pulse, button history
  int        m_state;
  bit        m_en;
  bit [31:0] m_tick;
  int        m_left;
  bit        m_s1, m_s2, m_lvl, m_pulse;
  int        m_streak;

  typedef struct {
    logic [1:0] md;
    logic       h;
    logic [1:0] st;
    logic       en;
  } vec_t;
  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_next(input int s, input int md, input bit h);
    if (s == 3) return (md == 0) ? 0 : 3;
    if (s != 0 && h) return 3;
    if (md == 0) return 0;
    if (md == 2) return 2;
    return 1;
  endfunction

  function automatic void model_reset();
    m_state = 0; m_en = 0; m_tick = 0; m_left = 0;
    m_s1 = 0; m_s2 = 0; m_lvl = 0; m_pulse = 0; m_streak = 0;
  endfunction

  function automatic void model_update();
    bit en_new, pulse_new;
    int left_new;
    if (!reset) begin
      model_reset();
      return;
    end
    en_new = 0;
    if (!halt_req) begin
      if (m_state == 1 && mode == 2'd3) en_new = 1;
      if (m_state == 1 && mode == 2'd1 && m_left == 0) en_new = 1;
      if (m_state == 2 && m_pulse) en_new = 1;
    end
    if (m_state == 1 && mode == 2'd1)
      left_new = (m_left == 0) ? int'(div_val) : m_left - 1;
    else
      left_new = int'(div_val);
    pulse_new = 0;
    if (m_s2 != m_lvl) begin
      if (m_streak + 1 == DB) begin
        m_lvl = m_s2; m_streak = 0; pulse_new = m_s2;
      end else begin
        m_streak++;
      end
    end else begin
      m_streak = 0;
    end
    m_s2 = m_s1;
    m_s1 = step_btn;
    m_tick  = m_tick + 32'(m_en);
    m_state = model_next(m_state, int'(mode), halt_req);
    m_en    = en_new;
    m_left  = left_new;
    m_pulse = pulse_new;
  endfunction

  task automatic step_cycle();
    @(posedge sys_clk);
    model_update();
    @(negedge sys_clk);
    chk("cpu_en", 32'(cpu_en), 32'(m_en));
    chk("tick_cnt", tick_cnt, m_tick);
    chk("state", 32'(state), m_state);
    chk("stopped", 32'(stopped), 32'(m_state == 3));
  endtask

  task automatic reset_dut();
    mode = 2'd0; halt_req = 0; step_btn = 0;
    reset = 0;
    model_reset();
    repeat (3) step_cycle();
    reset = 1;
  endtask

  task automatic wait_pulse(output int n);
    n = 0;
    do begin
      step_cycle();
      n++;
    end while (!cpu_en && n < 64);
    if (!cpu_en) chk("pulse_timeout", 32'(n), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int gap, n, pulses, last, first;
    int t0;
    bit prev;

    vecs[0]  = '{2'd0, 1'b0, 2'd0, 1'b0};
    vecs[1]  = '{2'd1, 1'b0, 2'd1, 1'b0};
    vecs[2]  = '{2'd1, 1'b0, 2'd1, 1'b1};
    vecs[3]  = '{2'd3, 1'b0, 2'd1, 1'b1};
    vecs[4]  = '{2'd1, 1'b0, 2'd1, 1'b1};
    vecs[5]  = '{2'd2, 1'b0, 2'd2, 1'b0};
    vecs[6]  = '{2'd3, 1'b0, 2'd1, 1'b0};
    vecs[7]  = '{2'd0, 1'b0, 2'd0, 1'b0};
    vecs[8]  = '{2'd2, 1'b0, 2'd2, 1'b0};
    vecs[9]  = '{2'd1, 1'b0, 2'd1, 1'b0};
    vecs[10] = '{2'd3, 1'b1, 2'd3, 1'b0};
    vecs[11] = '{2'd1, 1'b0, 2'd3, 1'b0};
    vecs[12] = '{2'd3, 1'b1, 2'd3, 1'b0};
    vecs[13] = '{2'd0, 1'b1, 2'd0, 1'b0};
    vecs[14] = '{2'd2, 1'b0, 2'd2, 1'b0};
    vecs[15] = '{2'd2, 1'b1, 2'd3, 1'b0};
    vecs[16] = '{2'd0, 1'b0, 2'd0, 1'b0};
    vecs[17] = '{2'd1, 1'b1, 2'd1, 1'b0};
    vecs[18] = '{2'd1, 1'b1, 2'd3, 1'b0};
    vecs[19] = '{2'd0, 1'b0, 2'd0, 1'b0};

    model_reset();
    reset_dut();
    chk("rst_en", 32'(cpu_en), 0);
    chk("rst_tick", tick_cnt, 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_stopped", 32'(stopped), 0);

    // FSM transition table with div_val=0
    div_val = '0;
    for (int i = 0; i < 20; i++) begin
      mode = vecs[i].md;
      halt_req = vecs[i].h;
      step_cycle();
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("vec%0d_en", i), 32'(cpu_en), 32'(vecs[i].en));
    end
    halt_req = 0;

    // Divided run, div_val=3
    reset_dut();
    mode = 2'd1; div_val = CNT_W'(3);
    pulses = 0; last = 0; first = 0; prev = 0;
    for (int i = 1; i <= 40; i++) begin
      step_cycle();
      if (cpu_en) begin
        if (pulses == 0) first = i;
        else chk("div_gap", 32'(i - last), 4);
        chk("div_width", 32'(prev), 0);
        pulses++;
        last = i;
      end
      prev = cpu_en;
    end
    chk("div_first", 32'(first), 5);
    chk("div_pulses", 32'(pulses), 9);
    chk("div_ticks", tick_cnt, 32'(pulses - int'(cpu_en)));
    chk("div_state", 32'(state), 1);

    // Full speed, then halt after 10 enables
    reset_dut();
    mode = 2'd3;
    n = 0;
    for (int i = 0; i < 40 && n < 10; i++) begin
      step_cycle();
      if (cpu_en) n++;
    end
    chk("full_count", 32'(n), 10);
    halt_req = 1;
    step_cycle();
    halt_req = 0;
    chk("halt_en", 32'(cpu_en), 0);
    chk("halt_stopped", 32'(stopped), 1);
    chk("halt_state", 32'(state), 3);
    chk("halt_tick", tick_cnt, 10);
    mode = 2'd1;
    repeat (5) step_cycle();
    chk("stop_hold_state", 32'(state), 3);
    chk("stop_hold_tick", tick_cnt, 10);
    mode = 2'd0;
    step_cycle();
    chk("stop_exit_state", 32'(state), 0);

    // Single-step with press and release bounce
    reset_dut();
    mode = 2'd2;
    repeat (3) step_cycle();
    t0 = int'(tick_cnt);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step_btn = ((i / 3) % 2 == 0);
      step_cycle(); if (cpu_en) n++;
    end
    step_btn = 1;
    for (int i = 0; i < 30; i++) begin step_cycle(); if (cpu_en) n++; end
    for (int i = 0; i < 20; i++) begin
      step_btn = ((i / 3) % 2 == 1);
      step_cycle(); if (cpu_en) n++;
    end
    step_btn = 0;
    for (int i = 0; i < 30; i++) begin step_cycle(); if (cpu_en) n++; end
    chk("step_pulses", 32'(n), 1);
    chk("step_ticks", tick_cnt - 32'(t0), 1);

    // div_val change mid-count, then div_val=0
    mode = 2'd1; div_val = CNT_W'(5);
    wait_pulse(gap);
    step_cycle(); step_cycle();
    div_val = CNT_W'(1);
    wait_pulse(gap);
    chk("chg_gap_old", 32'(gap + 2), 6);
    wait_pulse(gap);
    chk("chg_gap_new1", 32'(gap), 2);
    wait_pulse(gap);
    chk("chg_gap_new2", 32'(gap), 2);
    div_val = '0;
    wait_pulse(gap);
    for (int i = 0; i < 4; i++) begin
      step_cycle();
      chk("div0_every", 32'(cpu_en), 1);
    end

    // halt_req in the terminal-count cycle
    mode = 2'd0; step_cycle();
    mode = 2'd1; div_val = CNT_W'(2);
    wait_pulse(gap);
    step_cycle(); step_cycle();
    halt_req = 1;
    step_cycle();
    halt_req = 0;
    chk("prio_en", 32'(cpu_en), 0);
    chk("prio_state", 32'(state), 3);
    mode = 2'd0; step_cycle();

    // Asynchronous reset between edges
    reset_dut();
    mode = 2'd3;
    for (int i = 0; i < 100 && tick_cnt != 50; i++) step_cycle();
    chk("pre_rst_tick", tick_cnt, 50);
    #2;
    reset = 0;
    model_reset();
    #1;
    chk("async_en", 32'(cpu_en), 0);
    chk("async_tick", tick_cnt, 0);
    chk("async_state", 32'(state), 0);
    chk("async_stopped", 32'(stopped), 0);
    step_cycle(); step_cycle();
    reset = 1;
    step_cycle();
    chk("post_rst_en", 32'(cpu_en), 0);
    mode = 2'd0; step_cycle(); step_cycle();

    // tick_cnt wrap
    force dut.tick_cnt = 32'hFFFF_FFFF;
    m_tick = 32'hFFFF_FFFF;
    step_cycle();
    release dut.tick_cnt;
    step_cycle();
    mode = 2'd3;
    step_cycle();
    step_cycle();
    chk("wrap_pulse", 32'(cpu_en), 1);
    mode = 2'd0;
    step_cycle();
    chk("wrap_tick", tick_cnt, 0);

    // Randomized traffic against the model
    reset_dut();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) div_val = CNT_W'($urandom_range(0, 5));
      halt_req = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 5) == 0) step_btn = ~step_btn;
      step_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
